// File: rtl/f_fetch_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select codes, reset values
// and the branch-offset helper used by the next-PC logic.
package f_fetch_stage_pkg;

  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_J      = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Word offset of a branch: sign-extend imm16 first, then scale by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/f_fetch_stage_npc.sv
// Combinational next-PC selection from the D-stage decode and comparator.
module f_fetch_stage_npc
  import f_fetch_stage_pkg::*;
(
  input  logic [31:0] F_pc,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_instr,
  input  logic [2:0]  npc_op,
  input  logic        cmp,
  input  logic [31:0] D_rs_fwd,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_opcode;

  assign pc4           = F_pc + 32'd4;
  assign branch_target = D_pc + 32'd4 + branch_offset(D_instr[15:0]);
  assign jump_target   = {D_pc[31:28], D_instr[25:0], 2'b00};
  assign unused_opcode = ^D_instr[31:26];

  always_comb begin
    next_pc = pc4;
    case (npc_op)
      NPC_PC4:    next_pc = pc4;
      NPC_BRANCH: next_pc = cmp ? branch_target : pc4;
      NPC_J:      next_pc = jump_target;
      NPC_JR:     next_pc = D_rs_fwd;
      default:    next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: PC register, next-PC mux and IF/ID pipeline register.
// The instruction behind a branch/jump is the delay slot and is never flushed.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] F_instr,
  input  logic [2:0]  npc_op,
  input  logic        cmp,
  input  logic [31:0] D_rs_fwd,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8
);

  logic [31:0] next_pc;

  f_fetch_stage_npc u_npc (
    .F_pc     (F_pc),
    .D_pc     (D_pc),
    .D_instr  (D_instr),
    .npc_op   (npc_op),
    .cmp      (cmp),
    .D_rs_fwd (D_rs_fwd),
    .next_pc  (next_pc)
  );

  // stall freezes PC and IF/ID together; a redirect pending in D is simply
  // re-evaluated on the first unstalled edge with the then-current cmp/rs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_pc    <= PC_RESET;
      D_instr <= NOP_INSTR;
      D_pc    <= PC_RESET;
      D_pc8   <= PC_RESET + 32'd8;
    end else if (!stall) begin
      F_pc    <= next_pc;
      D_instr <= F_instr;
      D_pc    <= F_pc;
      D_pc8   <= F_pc + 32'd8;
    end
  end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and computes next-PC from the D-stage comparator result (cmp) and the D-stage jump/branch decode.
- Drives the instruction-memory address and registers the fetched instruction, PC and link address into D.
- Architectural branch delay slot: the F-stage instruction behind a branch/jump always executes and is never flushed.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset (text-segment base).
- NOP_INSTR, 32'h0000_0000, instruction word loaded into the D register on reset.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears PC and IF/ID register immediately
- stall  input  1  hazard-unit stall; freezes PC and IF/ID register
- F_instr  input  32  instruction word read combinationally from IM at F_pc
- npc_op  input  3  D-stage next-PC select (NPC_pc4, NPC_branch, NPC_j, NPC_jr)
- cmp  input  1  D-stage comparator result; branch-taken qualifier for NPC_branch
- D_rs_fwd  input  32  forwarded rs value in D, jr target
- F_pc  output  32  current fetch PC to IM
- D_instr  output  32  registered instruction in D
- D_pc  output  32  registered PC of D_instr
- D_pc8  output  32  D_pc + 8, link address for jal/jalr

Behaviour:
- Reset (async, any time incl. mid-stall): F_pc=PC_RESET, D_instr=NOP_INSTR, D_pc=PC_RESET, D_pc8=PC_RESET+8. Reset dominates stall.
- Redirect target computed combinationally from D_instr/D_pc:
  - NPC_pc4: F_pc+4
  - NPC_branch: cmp ? D_pc+4+(sext(D_instr[15:0])<<2) : F_pc+4
  - NPC_j: {D_pc[31:28], D_instr[25:0], 2'b00}
  - NPC_jr: D_rs_fwd used unmodified; no alignment check
  - undefined codes: F_pc+4
- Arithmetic: 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0; negative offsets sign-extended before shift.
- Clock edge, stall=0: F_pc<=next-PC; D_instr<=F_instr; D_pc<=F_pc; D_pc8<=F_pc+8.
- Clock edge, stall=1: F_pc, D_instr, D_pc, D_pc8 all hold. The redirect is not taken while stalled; it is re-evaluated on the first unstalled edge with the then-current cmp/D_rs_fwd.
- Delay-slot timing: a branch in D at cycle t redirects F_pc at edge t+1. The instruction fetched at t (PC = D_pc+4) enters D normally. Zero-cycle penalty beyond the delay slot.
- Back-to-back jumps (jump in delay slot): each redirect is honoured in turn, no special casing.
- Latency: F_instr appears on D_instr one edge after fetch. F_pc changes only on clock edges or reset.
- No internal FSM beyond the PC/IF-ID registers. No other outputs.

Decomposition:
- Shared header const.v: NPC_pc4=3'd0, NPC_branch=3'd1, NPC_j=3'd2, NPC_jr=3'd3, alongside existing CMP_* codes. Also PC_RESET default.
- One combinational sub-module, npc (inputs F_pc, D_pc, D_instr, npc_op, cmp, D_rs_fwd; output next_pc).
- PC register and IF/ID register live in f_fetch_stage.

Test Plan:
- Reset: assert reset mid-cycle with stall=1 -> F_pc=0x3000, D_instr=0, D_pc=0x3000, D_pc8=0x3008 without waiting for clk. Release, 3 edges npc_op=pc4 -> F_pc 0x3004, 0x3008, 0x300C.
- Taken branch: D_pc=0x3008, imm16=0xFFFE, npc_op=branch, cmp=1 -> next F_pc=0x3004. Delay slot 0x300C reaches D. Same with cmp=0 -> F_pc=F_pc+4.
- Jump/jr: D_pc=0x3010, j imm26=0x0000C10 -> F_pc=0x0000_3040. jr with D_rs_fwd=0x0000_3100 -> F_pc=0x3100. D_pc8 for jal at 0x3010 = 0x3018.
- Stall: stall=1 for 3 cycles with branch in D, cmp toggling 1->0->1, then stall=0 with cmp=0 -> PC/IF-ID held throughout; not-taken on release (F_pc+4).
- Wrap: F_pc forced to 0xFFFF_FFFC, npc_op=pc4 -> F_pc=0x0000_0000.
- Jump in delay slot: j at 0x3000 to 0x3100, j at 0x3004 to 0x3200 -> fetch sequence 0x3000, 0x3004, 0x3100, 0x3200.
